// File: rtl/rf_write_scheduler.sv
// rf_write_scheduler: arbitrates the register file's single write port between
// the in-order pipeline writeback and a long-latency unit (load/divide), keeps
// a 32-entry pending scoreboard, flags decode source hazards and forces a
// one-cycle pipeline stall when the long-latency result has been starved.
//
// Handshake (long-latency result): lu_valid/lu_waddr/lu_wdata are held stable
// by the producer until lu_ready is seen high; a transfer ("fire") happens in a
// cycle where lu_valid & lu_ready. lu_ready is a pure function of the current
// cycle (stall_pipe | ~pipe_we) and does not depend on lu_valid.
module rf_write_scheduler #(
    parameter int STARVE_LIMIT = 4,
    localparam int CW = $clog2(STARVE_LIMIT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pipe_we,
    input  logic [4:0]    pipe_waddr,
    input  logic [31:0]   pipe_wdata,
    input  logic          lu_valid,
    input  logic [4:0]    lu_waddr,
    input  logic [31:0]   lu_wdata,
    output logic          lu_ready,
    input  logic          issue_valid,
    input  logic [4:0]    issue_rd,
    input  logic [4:0]    rs1_addr,
    input  logic [4:0]    rs2_addr,
    output logic          hazard,
    output logic          stall_pipe,
    output logic          rf_we,
    output logic [4:0]    rf_waddr,
    output logic [31:0]   rf_wdata,
    output logic [31:0]   pending,
    output logic          protocol_err,
    output logic          dbg_state,
    output logic [CW-1:0] dbg_wait_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_WAIT = CW'(STARVE_LIMIT - 1);

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          lu_fire;
    logic          lu_denied;
    logic          haz_rs1;
    logic          haz_rs2;
    logic [31:0]   pending_nxt;
    logic          err_now;

    // The pipeline cannot be back-pressured, so lu only gets the port when the
    // pipe is idle or has been told to hold its writeback.
    assign lu_ready  = stall_pipe | ~pipe_we;
    assign lu_fire   = lu_valid & lu_ready;
    assign lu_denied = lu_valid & ~lu_ready;

    assign dbg_state    = (state == STALL);
    assign dbg_wait_cnt = wait_cnt;

    // Write port mux: a firing lu result always owns the port; otherwise the
    // pipe writeback passes straight through (x0 writes included).
    always_comb begin
        rf_we    = pipe_we;
        rf_waddr = pipe_waddr;
        rf_wdata = pipe_wdata;
        if (lu_fire) begin
            rf_we    = 1'b1;
            rf_waddr = lu_waddr;
            rf_wdata = lu_wdata;
        end
    end

    // Source hazard: pending and not covered by this cycle's forwarded write.
    always_comb begin
        haz_rs1 = (rs1_addr != 5'd0) && pending[rs1_addr] &&
                  !(rf_we && (rf_waddr == rs1_addr));
        haz_rs2 = (rs2_addr != 5'd0) && pending[rs2_addr] &&
                  !(rf_we && (rf_waddr == rs2_addr));
        hazard  = haz_rs1 | haz_rs2;
    end

    // Next scoreboard: clear on fire first so a same-register issue wins.
    always_comb begin
        pending_nxt = pending;
        if (lu_fire) begin
            pending_nxt[lu_waddr] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // Protocol violations seen this cycle.
    always_comb begin
        err_now = 1'b0;
        if (pipe_we && stall_pipe) begin
            err_now = 1'b1;
        end
        if (issue_valid && (issue_rd != 5'd0) && pending[issue_rd] &&
            !(lu_fire && (lu_waddr == issue_rd))) begin
            err_now = 1'b1;
        end
        if (lu_fire && !pending[lu_waddr]) begin
            err_now = 1'b1;
        end
    end

    // Scoreboard and sticky error register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending      <= 32'd0;
            protocol_err <= 1'b0;
        end else begin
            pending      <= pending_nxt;
            protocol_err <= protocol_err | err_now;
        end
    end

    // Starvation FSM: count denied cycles, then grant via a one-cycle stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            stall_pipe <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (lu_denied) begin
                        if (wait_cnt == LAST_WAIT) begin
                            state      <= STALL;
                            stall_pipe <= 1'b1;
                            wait_cnt   <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                STALL: begin
                    state      <= RUN;
                    stall_pipe <= 1'b0;
                    wait_cnt   <= '0;
                end
                default: begin
                    state      <= RUN;
                    stall_pipe <= 1'b0;
                    wait_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
